// File: rtl/srt_pkg.sv
// Shared definitions for the SRT matrix-vector stream controller.
// State encoding and default pipeline geometry.
package srt_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_LOAD   = 2'd1;
  localparam state_t ST_STREAM = 2'd2;
  localparam state_t ST_DRAIN  = 2'd3;

  localparam int LANES_DEF     = 4;
  localparam int MAT_BEATS_DEF = 3;
  localparam int PIPE_LAT_DEF  = 40;
  localparam int CREDITS_DEF   = 8;

endpackage

// File: rtl/srt_stream_ctrl_valid_delay_line.sv
// Fixed-depth {last,valid} shift register that mirrors the datapath latency.
// any_valid only looks at stages that have not yet reached the output.
module valid_delay_line #(
  parameter int DEPTH = 40,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             any_valid
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

  // The output stage is excluded so DRAIN can exit as the last result leaves.
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH-1; i++) any_valid = any_valid | sr[i][0];
  end

endmodule

// File: rtl/srt_stream_ctrl.sv
// Sequencer for the SRT matrix-vector + CORDIC magnitude datapath:
// matrix load, vector streaming, latency tracking and output credits.
module srt_stream_ctrl
  import srt_pkg::*;
#(
  parameter int LANES     = LANES_DEF,
  parameter int MAT_BEATS = MAT_BEATS_DEF,
  parameter int PIPE_LAT  = PIPE_LAT_DEF,
  parameter int CREDITS   = CREDITS_DEF,
  parameter int CRED_W    = $clog2(CREDITS+1)
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic       load_matrix,
  output logic [1:0] mat_beat,
  output logic       vec_valid,
  output logic       pipe_valid,
  output logic       pipe_last,
  input  logic       out_pop,
  output logic [1:0] state_o,
  output logic       done,
  output logic       err_short,
  output logic       err_credit
);

  if (PIPE_LAT < 2 || CREDITS < 1 || LANES < 1) begin : g_bad_cfg
    $error("srt_stream_ctrl: illegal parameters");
  end

  localparam logic [1:0]        LAST_BEAT = 2'(MAT_BEATS-1);
  localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(CREDITS);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        beat;
  logic [CRED_W-1:0] credits;
  logic              hs;
  logic              any_valid;
  logic [1:0]        dl_out;

  assign hs      = s_tvalid & s_tready;
  assign state_o = state;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      beat      <= 2'd0;
      done      <= 1'b0;
      err_short <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == ST_DRAIN) && (state_nxt == ST_IDLE);
      if (hs && s_tlast && (state == ST_IDLE || state == ST_LOAD))
        err_short <= 1'b1;
      if (load_matrix)
        beat <= (state_nxt == ST_LOAD) ? beat + 2'd1 : 2'd0;
      else if (state_nxt == ST_IDLE)
        beat <= 2'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (hs) begin
          if (s_tlast)             state_nxt = ST_IDLE;
          else if (MAT_BEATS == 1) state_nxt = ST_STREAM;
          else                     state_nxt = ST_LOAD;
        end
      ST_LOAD:
        if (hs) begin
          if (s_tlast)                state_nxt = ST_IDLE;
          else if (beat == LAST_BEAT) state_nxt = ST_STREAM;
        end
      ST_STREAM:
        if (hs && s_tlast) state_nxt = ST_DRAIN;
      default:
        if (!any_valid && !hs) state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_tready    = 1'b0;
    load_matrix = 1'b0;
    mat_beat    = 2'd0;
    vec_valid   = 1'b0;
    if (aresetn) begin
      unique case (state)
        ST_IDLE: begin
          s_tready    = 1'b1;
          load_matrix = s_tvalid & ~s_tlast;
        end
        ST_LOAD: begin
          s_tready    = 1'b1;
          load_matrix = s_tvalid & ~s_tlast;
          mat_beat    = beat;
        end
        ST_STREAM: begin
          s_tready  = (credits != '0);
          vec_valid = s_tvalid & s_tready;
        end
        default: ;
      endcase
    end
  end

  // One credit per issued vector, returned by each output FIFO pop.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      credits    <= CRED_MAX;
      err_credit <= 1'b0;
    end else if (vec_valid && !out_pop) begin
      credits <= credits - CRED_W'(1);
    end else if (!vec_valid && out_pop) begin
      if (credits == CRED_MAX) err_credit <= 1'b1;
      else                     credits    <= credits + CRED_W'(1);
    end
  end

  valid_delay_line #(
    .DEPTH (PIPE_LAT),
    .WIDTH (2)
  ) u_dly (
    .clk       (aclk),
    .rst_n     (aresetn),
    .din       ({vec_valid & s_tlast, vec_valid}),
    .dout      (dl_out),
    .any_valid (any_valid)
  );

  assign pipe_valid = dl_out[0];
  assign pipe_last  = dl_out[1];

endmodule

// File: doc/srt_stream_ctrl.md
Name: srt_stream_ctrl

Overview:
- Sequencer for the SRT matrix-vector + CORDIC magnitude datapath.
- First accepts a matrix (MAT_BEATS beats), then streams vectors into the datapath.
- Tracks valid/last through the fixed-latency, non-stallable pipeline.
- Applies credit-based backpressure on the input so the downstream output FIFO can never overflow. This replaces the unconditional s_tready=1 scheme.

Parameters:
- LANES, 4, elements per input beat (informational; the controller carries no data).
- MAT_BEATS, 3, input beats forming one matrix (3x4 matrix, one row per beat).
- PIPE_LAT, 40, cycles from vector issue to result valid at the pipeline output; must be ≥2.
- CREDITS, 8, depth of the downstream output FIFO in entries; must be ≥1.
- CRED_W, $clog2(CREDITS+1), credit counter width.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- aresetn  in  1  reset; synchronous, active-low.
- s_tvalid  in  1  upstream AXIS valid.
- s_tlast  in  1  upstream AXIS last; marks the final vector of a job.
- s_tready  out  1  upstream AXIS ready.
- load_matrix  out  1  datapath captures s_tdata as matrix row mat_beat this cycle.
- mat_beat  out  2  row index for load_matrix (0..MAT_BEATS-1).
- vec_valid  out  1  datapath accepts s_tdata as a vector this cycle.
- pipe_valid  out  1  result valid at pipeline output; pushes the output FIFO.
- pipe_last  out  1  result is the job's last; travels with pipe_valid.
- out_pop  in  1  one entry left the output FIFO (m_tvalid & m_tready downstream).
- state_o  out  2  current FSM state.
- done  out  1  one-cycle pulse when a job fully drains.
- err_short  out  1  sticky: s_tlast seen during matrix load.
- err_credit  out  1  sticky: out_pop received with credits already at CREDITS.

Behaviour:
- Reset (aresetn=0 at an edge):
  - state=IDLE, beat counter=0, credits=CREDITS, delay lines cleared.
  - done=0, err_short=0, err_credit=0.
  - s_tready, load_matrix and vec_valid are forced 0 while aresetn=0.
  - A mid-job reset discards all in-flight results without emitting pipe_valid.
- hs = s_tvalid & s_tready.
- States are IDLE(0), LOAD(1), STREAM(2), DRAIN(3).
- IDLE:
  - s_tready=1.
  - On hs: load_matrix=1, mat_beat=0.
  - If MAT_BEATS==1, go to STREAM; else go to LOAD with beat=1.
- LOAD:
  - s_tready=1.
  - On hs: load_matrix=1, mat_beat=beat.
  - If beat==MAT_BEATS-1, go to STREAM; else beat+1.
  - On hs with s_tlast=1 before the final beat (including in IDLE): set err_short, no load_matrix, go to IDLE.
  - s_tlast on the final matrix beat is also an error and is handled the same way.
- STREAM:
  - s_tready = (credits != 0).
  - On hs: vec_valid=1, credits decrement, and a 1 is pushed into the valid delay line with s_tlast into the last delay line.
  - On hs with s_tlast, go to DRAIN.
- DRAIN:
  - s_tready=0.
  - When the delay line holds no valid bit and no hs occurs, go to IDLE.
  - done pulses 1 in the cycle the state changes DRAIN to IDLE.
  - The matrix is reloaded for every job.
- Delay line:
  - Shifts every cycle in all states; pipe_valid/pipe_last = bit PIPE_LAT-1.
  - Latency is exactly PIPE_LAT cycles from vec_valid to pipe_valid.
  - A cycle without hs shifts in 0.
- Credits:
  - Same-cycle issue and out_pop leaves credits unchanged.
  - out_pop alone increments credits, saturating at CREDITS; at CREDITS, set err_credit and hold.
  - Credits persist across jobs; returning to IDLE does not reset them.
- load_matrix, mat_beat, vec_valid and s_tready are combinational from registered state plus s_tvalid.
- All other outputs are registered.

Decomposition:
- Shared package srt_pkg holds:
  - the state encoding localparams ST_IDLE/ST_LOAD/ST_STREAM/ST_DRAIN;
  - the PIPE_LAT default;
  - the MAT_BEATS default.
- One sub-module, valid_delay_line (parameters DEPTH, WIDTH=2), carries the {last,valid} shift register.
  - It has a sync active-low clear.
  - It has an any_valid output used for the DRAIN exit.

Test Plan:
1. Reset, then 3 matrix beats back-to-back → load_matrix high in cycles 0,1,2 with mat_beat 0,1,2, state_o=2 after cycle 2.
2. Matrix, then 5 vectors with tlast on the 5th, out_pop asserted each cycle → vec_valid 5 cycles, pipe_valid exactly 40 cycles later for 5 cycles, pipe_last on the 5th, done one cycle after the last pipe_valid.
3. CREDITS=8, 12 vectors, no out_pop → s_tready drops after 8 issues and the 9th vector stalls; a single out_pop re-opens s_tready next cycle for exactly one issue.
4. Same-cycle hs and out_pop with credits=3 → credits stay 3; out_pop at credits=8 → err_credit=1 and credits stay 8.
5. tlast on matrix beat 1 → err_short=1, no load_matrix for that beat, state_o=0; the next job loads normally.
6. Reset asserted at cycle 10 of 20 in-flight results → no pipe_valid after reset, credits=8, state_o=0.
